// File: rtl/awg_cmd_player.sv
// SPI-fed arbitrary waveform player: assembles 32-bit commands from bytes, loads
// a sample RAM and streams it to the DAC bus at a programmable rate.
//   state | meaning
//   IDLE  | output parked at IDLE_CODE, waiting for RUN
//   PLAY  | divider running, one RAM read per tick
//   HOLD  | one-shot finished, last sample held on the bus
module awg_cmd_player #(
   parameter int          DATA_W    = 14,
   parameter int          ADDR_W    = 8,
   parameter int          DIV_W     = 16,
   parameter logic [13:0] IDLE_CODE = 14'h2000
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic              i_RX_DV,
   input  logic [7:0]        i_RX_Byte,
   input  logic              i_CS_n,
   output logic [DATA_W-1:0] o_Dac,
   output logic              o_Dac_Valid,
   output logic              o_Busy,
   output logic              o_Done,
   output logic              o_Err,
   output logic [1:0]        o_State
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_HOLD = 2'd2} state_t;

   localparam logic [3:0] OP_NOP = 4'd0, OP_WRITE = 4'd1, OP_RUN = 4'd2,
                          OP_STOP = 4'd3, OP_LEN = 4'd4, OP_DIV = 4'd5;
   localparam logic [DATA_W-1:0] IDLE_D = IDLE_CODE[DATA_W-1:0];

   state_t            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [23:0]       shift_q, shift_d;
   logic [31:0]       word_q, word_d;
   logic              dec_v_q, dec_v_d;
   logic              mode_q, mode_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic              show_q, show_d;
   logic              dac_v_q, dac_v_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] rd_q;
   logic [DATA_W-1:0] ram [2**ADDR_W];
   logic [3:0]        op;
   logic              unused_word_bits;

   assign op               = word_q[31:28];
   assign unused_word_bits = ^word_q;

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      word_d     = word_q;
      dec_v_d    = 1'b0;
      mode_d     = mode_q;
      len_d      = len_q;
      addr_d     = addr_q;
      div_d      = div_q;
      div_cnt_d  = div_cnt_q;
      show_d     = show_q;
      dac_v_d    = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      ram_we     = 1'b0;

      // Chip-select high drops any partial word, even if a byte lands the same cycle
      if (i_CS_n) begin
         byte_cnt_d = 2'd0;
      end else if (i_RX_DV) begin
         shift_d = {shift_q[15:0], i_RX_Byte};
         if (byte_cnt_q == 2'd3) begin
            word_d     = {shift_q, i_RX_Byte};
            dec_v_d    = 1'b1;
            byte_cnt_d = 2'd0;
         end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
         end
      end

      if (state_q == S_PLAY) begin
         if (div_cnt_q == '0) begin
            div_cnt_d = div_q;
            dac_v_d   = 1'b1;
            show_d    = 1'b1;
            addr_d    = (addr_q == len_q) ? '0 : addr_q + ADDR_W'(1);
            if (addr_q == len_q && mode_q) begin
               state_d = S_HOLD;
               done_d  = 1'b1;
            end
         end else begin
            div_cnt_d = div_cnt_q - DIV_W'(1);
         end
      end

      // Decode overrides the playback tick: RUN restarts, STOP parks the output
      if (dec_v_q) begin
         case (op)
            OP_NOP: ;
            OP_WRITE: begin
               if (state_q == S_PLAY) err_d = 1'b1;
               else                   ram_we = 1'b1;
            end
            OP_RUN: begin
               mode_d    = word_q[0];
               addr_d    = '0;
               div_cnt_d = '0;
               state_d   = S_PLAY;
               dac_v_d   = 1'b0;
               done_d    = 1'b0;
            end
            OP_STOP: begin
               state_d = S_IDLE;
               show_d  = 1'b0;
               dac_v_d = 1'b0;
               done_d  = 1'b0;
            end
            OP_LEN: begin
               if (state_q == S_PLAY) err_d = 1'b1;
               else                   len_d = word_q[ADDR_W-1:0];
            end
            OP_DIV:  div_d = word_q[DIV_W-1:0];
            default: err_d = 1'b1;
         endcase
      end

      busy_d   = (state_d == S_PLAY);
      ram_addr = ram_we ? word_q[14+ADDR_W-1:14] : addr_q;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= 2'd0;
         shift_q    <= '0;
         word_q     <= '0;
         dec_v_q    <= 1'b0;
         mode_q     <= 1'b0;
         len_q      <= '1;
         addr_q     <= '0;
         div_q      <= '0;
         div_cnt_q  <= '0;
         show_q     <= 1'b0;
         dac_v_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         word_q     <= word_d;
         dec_v_q    <= dec_v_d;
         mode_q     <= mode_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         div_q      <= div_d;
         div_cnt_q  <= div_cnt_d;
         show_q     <= show_d;
         dac_v_q    <= dac_v_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   // Single-port sample RAM; writes never occur in PLAY, reads only in PLAY
   always_ff @(posedge i_Clk) begin
      if (ram_we)       ram[ram_addr] <= word_q[DATA_W-1:0];
      else if (dac_v_d) rd_q <= ram[ram_addr];
   end

   assign o_Dac       = show_q ? rd_q : IDLE_D;
   assign o_Dac_Valid = dac_v_q;
   assign o_Busy      = busy_q;
   assign o_Done      = done_q;
   assign o_Err       = err_q;
   assign o_State     = state_q;

endmodule

// File: tb/tb_awg_cmd_player.sv
// Directed bench for awg_cmd_player: expected samples are queued as commands are
// sent and compared by a monitor as the DAC strobe appears.
module tb_awg_cmd_player;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_dv = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        cs_n = 1'b0;
   logic [13:0] dac;
   logic        dac_v, busy, done, err;
   logic [1:0]  state;

   typedef struct {
      logic        chk;
      logic [13:0] dac;
      logic        done;
      int          gap;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   err_cnt = 0;
   int   since_valid = 0;
   bit   strict = 1'b0;

   awg_cmd_player dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
      .i_CS_n(cs_n), .o_Dac(dac), .o_Dac_Valid(dac_v), .o_Busy(busy),
      .o_Done(done), .o_Err(err), .o_State(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   always @(posedge clk) begin
      #1;
      since_valid++;
      if (err) err_cnt++;
      if (done) chk("done_without_valid", 32'(dac_v), 32'd1);
      if (dac_v && (strict || sb.size() > 0)) begin
         chk("valid_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.chk) chk("sample", 32'(dac), 32'(e.dac));
            chk("done_flag", 32'(done), 32'(e.done));
            if (e.gap != 0) chk("valid_spacing", since_valid, e.gap);
         end
      end
      if (dac_v) since_valid = 0;
   end

   task automatic push(input logic c, input logic [13:0] d, input logic dn, input int g);
      exp_t e;
      e.chk = c; e.dac = d; e.done = dn; e.gap = g;
      sb.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_dv = 1'b1;
      rx_byte = b;
      @(negedge clk);
      rx_dv = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
   endtask

   task automatic drain(input string tag, input int budget);
      for (int k = 0; k < budget && sb.size() > 0; k++) begin
         @(posedge clk);
         #2;
      end
      chk(tag, sb.size(), 0);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dac", 32'(dac), 32'h2000);
      chk("rst_valid", 32'(dac_v), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_state", 32'(state), 0);
      rst_n = 1'b1;

      // address 5 sits in bits 21:14: bytes 10 01 40 7F
      send_word(32'h1001_407F);
      for (int i = 0; i < 5; i++) push(1'b0, 14'h0, 1'b0, (i == 0) ? 0 : 1);
      push(1'b1, 14'h007F, 1'b0, 1);
      strict = 1'b1;
      send_word(32'h2000_0000);
      drain("t1_drain", 40);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_state", 32'(state), 1);
      strict = 1'b0;
      send_word(32'h3000_0000);
      wait_clks(2);

      // one-shot, length 3, divider 2
      send_word(32'h1000_0100);
      send_word(32'h1000_4200);
      send_word(32'h1000_8300);
      send_word(32'h1000_C400);
      send_word(32'h4000_0003);
      send_word(32'h5000_0002);
      push(1'b1, 14'h100, 1'b0, 0);
      push(1'b1, 14'h200, 1'b0, 3);
      push(1'b1, 14'h300, 1'b0, 3);
      push(1'b1, 14'h400, 1'b1, 3);
      strict = 1'b1;
      send_word(32'h2000_0001);
      drain("t2_drain", 60);
      wait_clks(8);
      chk("t2_state_hold", 32'(state), 2);
      chk("t2_busy", 32'(busy), 0);
      chk("t2_dac_held", 32'(dac), 32'h400);

      // continuous wrap with no gap, then STOP wins over the tick
      send_word(32'h5000_0000);
      for (int i = 0; i < 8; i++) push(1'b1, 14'(32'h100 * (i % 4 + 1)), 1'b0, (i == 0) ? 0 : 1);
      send_word(32'h2000_0000);
      drain("t3_drain", 40);
      strict = 1'b0;
      send_word(32'h3000_0000);
      @(posedge clk);
      #1;
      chk("t3_stop_dac", 32'(dac), 32'h2000);
      chk("t3_stop_valid", 32'(dac_v), 0);
      chk("t3_stop_busy", 32'(busy), 0);
      chk("t3_stop_state", 32'(state), 0);

      // rejected commands during PLAY leave RAM, length and stream untouched
      for (int i = 0; i < 48; i++) push(1'b1, 14'(32'h100 * (i % 4 + 1)), 1'b0, (i == 0) ? 0 : 1);
      err_cnt = 0;
      strict = 1'b1;
      send_word(32'h2000_0000);
      send_word(32'h1000_3FFF);
      send_word(32'h4000_0001);
      send_word(32'hF000_0000);
      drain("t4_drain", 100);
      chk("t4_err_count", err_cnt, 3);
      strict = 1'b0;
      send_word(32'h3000_0000);
      wait_clks(2);

      // partial word and a byte colliding with chip-select are both discarded
      send_word(32'h2000_0000);
      wait_clks(4);
      err_cnt = 0;
      send_byte(8'h10);
      send_byte(8'h00);
      @(negedge clk);
      cs_n = 1'b1;
      rx_dv = 1'b1;
      rx_byte = 8'h30;
      @(negedge clk);
      cs_n = 1'b0;
      rx_dv = 1'b0;
      send_word(32'h3000_0000);
      wait_clks(2);
      chk("t5_state_idle", 32'(state), 0);
      chk("t5_no_err", err_cnt, 0);

      // length 0 one-shot yields exactly one sample
      send_word(32'h4000_0000);
      push(1'b1, 14'h100, 1'b1, 0);
      strict = 1'b1;
      send_word(32'h2000_0001);
      drain("t5b_drain", 30);
      wait_clks(8);
      chk("t5b_state_hold", 32'(state), 2);
      chk("t5b_dac", 32'(dac), 32'h100);
      strict = 1'b0;

      // asynchronous reset mid-playback with a partial word pending
      send_word(32'h2000_0000);
      wait_clks(5);
      send_byte(8'h30);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_dac", 32'(dac), 32'h2000);
      chk("t6_rst_valid", 32'(dac_v), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_done", 32'(done), 0);
      chk("t6_rst_err", 32'(err), 0);
      chk("t6_rst_state", 32'(state), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push(1'b1, 14'h100, 1'b0, 0);
      push(1'b1, 14'h200, 1'b0, 1);
      push(1'b1, 14'h300, 1'b0, 1);
      push(1'b1, 14'h400, 1'b0, 1);
      strict = 1'b1;
      send_word(32'h2000_0000);
      drain("t6_drain", 30);
      strict = 1'b0;
      send_word(32'h3000_0000);
      wait_clks(2);
      chk("t6_final_state", 32'(state), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
